cla_pipe_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla_slice.sv | 52 +++++
 rtl/cla_pipe_adder.sv | 145 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and elaboration-time configuration check for the pipelined
// carry-lookahead adder (cla_pipe_adder / cla_slice).
package cla_pkg;

    localparam int CHUNK_NARROW = 4;
    localparam int CHUNK_MID    = 8;
    localparam int CHUNK_WIDE   = 16;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic bit cfg_ok(input int width, input int chunk);
        bit legal_chunk;
        legal_chunk = (chunk == CHUNK_NARROW) || (chunk == CHUNK_MID) || (chunk == CHUNK_WIDE);
        return legal_chunk && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead slice; every internal carry is a
// flat sum-of-products of bit generate/propagate terms, never a ripple chain.
module cla_slice
    import cla_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output gp_t              gp
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   gc;
    logic [CHUNK:0]   pc;
    logic [CHUNK:0]   c;
    logic             t;

    assign g = a & b;
    assign p = a ^ b;

    // gc[i]: carry into bit i generated inside the slice; pc[i]: bits below i all propagate
    always_comb begin
        gc    = '0;
        pc    = '0;
        t     = 1'b0;
        pc[0] = 1'b1;
        for (int i = 1; i <= CHUNK; i++) begin
            pc[i] = 1'b1;
            for (int m = 0; m < i; m++) begin
                pc[i] = pc[i] & p[m];
            end
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) begin
                    t = t & p[m];
                end
                gc[i] = gc[i] | t;
            end
        end
    end

    assign c  = gc | (pc & {(CHUNK + 1){ci}});
    assign s  = p ^ c[CHUNK-1:0];
    assign co = c[CHUNK];
    assign gp = '{g: gc[CHUNK], p: pc[CHUNK]};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit lookahead slice per stage,
// single global enable. Define CLA_PIPE_FLAGS_EN to add registered ovf/zero outputs.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NSTG = WIDTH / CHUNK;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of CHUNK (>= CHUNK), CHUNK one of 4/8/16");
    end

    logic             adv;
    logic [NSTG-1:0]  v_q;
    logic [NSTG-1:0]  v_n;
    logic [NSTG-1:0]  c_q;
    logic [NSTG-1:0]  c_n;
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] a_n [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] b_n [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic [WIDTH-1:0] s_n [NSTG];
    gp_t              gp_unused [NSTG];
`ifdef CLA_PIPE_FLAGS_EN
    logic [NSTG-1:0]  z_q;
    logic [NSTG-1:0]  z_n;
    logic             ovf_q;
    logic             ovf_n;
`endif

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTG-1];
    assign s         = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
`ifdef CLA_PIPE_FLAGS_EN
    assign ovf       = ovf_q;
    assign zero      = z_q[NSTG-1];
`endif

    // Operands travel with the beat; finished low result slices are merged forward.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_mrg;
        logic             ci;
        logic [CHUNK-1:0] ss;

        if (k == 0) begin : g_head
            assign op_a   = a;
            assign op_b   = b ^ {WIDTH{sub}};
            assign ci     = sub | cin;
            assign s_in   = '0;
            assign v_n[k] = in_valid;
        end else begin : g_body
            assign op_a   = a_q[k-1];
            assign op_b   = b_q[k-1];
            assign ci     = c_q[k-1];
            assign s_in   = s_q[k-1];
            assign v_n[k] = v_q[k-1];
        end

        cla_slice #(.CHUNK(CHUNK)) u_slice (
            .a  (op_a[k*CHUNK +: CHUNK]),
            .b  (op_b[k*CHUNK +: CHUNK]),
            .ci (ci),
            .s  (ss),
            .co (c_n[k]),
            .gp (gp_unused[k])
        );

        always_comb begin
            s_mrg = s_in;
            s_mrg[k*CHUNK +: CHUNK] = ss;
        end

        assign a_n[k] = op_a;
        assign b_n[k] = op_b;
        assign s_n[k] = s_mrg;

`ifdef CLA_PIPE_FLAGS_EN
        if (k == 0) begin : g_z_head
            assign z_n[k] = ~|ss;
        end else begin : g_z_body
            assign z_n[k] = z_q[k-1] & ~|ss;
        end
        // Same-sign operands giving an opposite-sign sum: equals carry-in(MSB) ^ carry-out(MSB).
        if (k == NSTG - 1) begin : g_ovf
            assign ovf_n = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (ss[CHUNK-1] ^ op_a[WIDTH-1]);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef CLA_PIPE_FLAGS_EN
            z_q   <= '0;
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            v_q <= v_n;
            c_q <= c_n;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= a_n[k];
                b_q[k] <= b_n[k];
                s_q[k] <= s_n[k];
            end
`ifdef CLA_PIPE_FLAGS_EN
            z_q   <= z_n;
            ovf_q <= ovf_n;
`endif
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=32, CHUNK=8, 4 stages);
// flag outputs are checked when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_adder;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NSTG  = WIDTH / CHUNK;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
        logic             zero;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic             ovf;
    logic             zero;
`endif

    int   n_tests   = 0;
    int   n_fail    = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en    = 1'b0;
    int   mon_cyc   = 0;
    int   n_popped  = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    bit   stalled_prev = 1'b0;
    int   seen;

    logic [WIDTH-1:0] va [16];
    logic [WIDTH-1:0] vb [16];
    logic             vcin [16];
    logic             vsub [16];

    cla_pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "tb_cla_pipe_adder timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic msub);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] be;
        exp_t             e;
        be     = msub ? ~mb : mb;
        r      = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, (msub | mcin)};
        e.s    = r[WIDTH-1:0];
        e.c    = r[WIDTH];
        e.ovf  = (ma[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != ma[WIDTH-1]);
        e.zero = (r[WIDTH-1:0] == '0);
        return e;
    endfunction

    // Output monitor: a stalled beat must be the oldest expected one; consumed beats are popped in order.
    always @(negedge clk) begin
        mon_cyc++;
        if (mon_en) begin
            if (stalled_prev && exp_q.size() != 0) begin
                check_val("stall_valid", 64'(out_valid), 64'(1));
                check_val("stall_s", 64'(s), 64'(exp_q[0].s));
                check_val("stall_cout", 64'(cout), 64'(exp_q[0].c));
            end
            if (out_valid && out_ready) begin
                check_val("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("mon_s", 64'(s), 64'(mon_e.s));
                    check_val("mon_cout", 64'(cout), 64'(mon_e.c));
`ifdef CLA_PIPE_FLAGS_EN
                    check_val("mon_ovf", 64'(ovf), 64'(mon_e.ovf));
                    check_val("mon_zero", 64'(zero), 64'(mon_e.zero));
`endif
                    if (n_popped == 0) first_cyc = mon_cyc;
                    last_cyc = mon_cyc;
                    n_popped++;
                end
            end
        end
        stalled_prev = mon_en && out_valid && !out_ready;
    end

    task automatic single_beat(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tcin, input logic tsub, input logic [WIDTH-1:0] es,
                               input logic ec, input logic eovf, input logic ezero);
        int lat;
        @(posedge clk);
        #1;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(NSTG));
        check_val({tag, "_s"}, 64'(s), 64'(es));
        check_val({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef CLA_PIPE_FLAGS_EN
        check_val({tag, "_ovf"}, 64'(ovf), 64'(eovf));
        check_val({tag, "_zero"}, 64'(zero), 64'(ezero));
`endif
        @(posedge clk);
        #1;
        check_val({tag, "_bubble"}, 64'(out_valid), 64'(0));
    endtask

    task automatic drive_stream(input string tag, input int n, input int st0, input int stn);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        n_popped = 0;
        mon_en = 1'b1;
        while (i < n && cyc < 200) begin
            @(posedge clk);
            #1;
            out_ready = !(cyc >= st0 && cyc < st0 + stn);
            a = va[i]; b = vb[i]; cin = vcin[i]; sub = vsub[i]; in_valid = 1'b1;
            #1;
            if (out_valid && !out_ready) check_val({tag, "_in_ready"}, 64'(in_ready), 64'(0));
            if (in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                i++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(posedge clk);
        @(posedge clk);
        #1;
        check_val({tag, "_left"}, 64'(exp_q.size()), 64'(0));
        check_val({tag, "_count"}, 64'(n_popped), 64'(n));
        mon_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 16; i++) begin
            va[i]   = 32'h9E37_79B9 * 32'(i + 1);
            vb[i]   = 32'h7F4A_7C15 ^ (32'(i) << 9);
            vcin[i] = ((i % 2) == 1);
            vsub[i] = ((i % 4) >= 2);
        end
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vcin[0] = 1'b0; vsub[0] = 1'b0;
        va[5] = 32'h7FFF_FFFF; vb[5] = 32'h0000_0001; vcin[5] = 1'b0; vsub[5] = 1'b0;
        va[6] = 32'h0000_0005; vb[6] = 32'h0000_0007; vsub[6] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(out_valid), 64'(0));
        check_val("rst_s", 64'(s), 64'(0));
        check_val("rst_cout", 64'(cout), 64'(0));
        check_val("rst_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        single_beat("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single_beat("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        single_beat("ovf",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        single_beat("sub_eq",      32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        single_beat("cin_chunk",   32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        single_beat("sub_cin_ign", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        single_beat("chain",       32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);

        drive_stream("b2b", 16, 0, 0);
        check_val("b2b_span", 64'(last_cyc - first_cyc), 64'(15));

        drive_stream("stall", 12, 6, 5);

        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            a = 32'hFFFF_FF00 + 32'(k); b = 32'h0000_0200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("mid_pre_valid", 64'(out_valid), 64'(1));
        check_val("mid_pre_s", 64'(s), 64'(32'h0000_0100));
        check_val("mid_pre_cout", 64'(cout), 64'(1));
        #1 rst = 1'b1;
        #1;
        check_val("mid_rst_valid", 64'(out_valid), 64'(0));
        check_val("mid_rst_s", 64'(s), 64'(0));
        check_val("mid_rst_cout", 64'(cout), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_val("mid_flushed", 64'(seen), 64'(0));
        single_beat("post_rst", 32'h0000_1234, 32'h0000_0FFF, 1'b1, 1'b0, 32'h0000_2234, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
